mux16_out_ctrl: RTL and testbench

MUX16_OUT_CTRL -- requirements
Module: mux16_out_ctrl

---
 rtl/mux16_out_ctrl.sv | 149 ++++++++++++++
 tb/tb_mux16_out_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux16_out_ctrl.sv
`timescale 1ns/1ps
// mux16_out_ctrl
//   Sequences a full readout of 16 banks x 2**ADDR_W words through an
//   external 16:1 mux and streams the words out over a valid/ready port.
//   Issue order is address-major, bank-minor. Read data returns one cycle
//   after rd_en and is buffered in a 2-entry output FIFO.
//
//   Configuration macro: OUT_BITREV_EN -- when defined, banks within each
//   address are visited in 4-bit bit-reversed order instead of 0..15.
//   Data width comes from the shared define `D_width.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle readout request, honoured only when idle
//   busy            readout in progress
//   done            one-cycle pulse after the last beat is accepted
//   rd_en, rd_addr  bank read strobe and common bank address
//   sel_out         mux select, aligned with mux_q
//   mux_q           mux output, valid the cycle after rd_en
//   out_data/out_valid/out_ready  downstream stream
`ifndef D_width
`define D_width 16
`endif

module mux16_out_ctrl #(
   parameter int ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  rd_en,
   output logic [ADDR_W-1:0]     rd_addr,
   output logic [3:0]            sel_out,
   input  logic [`D_width-1:0]   mux_q,
   output logic [`D_width-1:0]   out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

   state_t               state;
   logic [3:0]           bank_cnt;
   logic [ADDR_W-1:0]    addr_cnt;
   logic [3:0]           bank_seq;
   logic [`D_width-1:0]  fifo_mem [2];
   logic                 wr_ptr;
   logic                 rd_ptr;
   logic [1:0]           fifo_cnt;
   logic [1:0]           fifo_cnt_nxt;
   logic                 cap_pend;   // read issued last cycle, data on mux_q now
   logic                 push;
   logic                 pop;
   logic                 last_issue;
   logic [2:0]           level;

`ifdef OUT_BITREV_EN
   assign bank_seq = {bank_cnt[0], bank_cnt[1], bank_cnt[2], bank_cnt[3]};
`else
   assign bank_seq = bank_cnt;
`endif

   assign out_valid = (fifo_cnt != 2'd0);
   assign out_data  = fifo_mem[rd_ptr];
   assign rd_addr   = addr_cnt;

   // A new read is allowed when the words already owed to the FIFO
   // (stored + landing this cycle), less the beat leaving this cycle,
   // leave room for it. Crediting the current pop is what sustains one
   // beat per cycle with only two entries.
   always_comb begin
      push         = cap_pend;
      pop          = out_valid && out_ready;
      level        = {1'b0, fifo_cnt} + {2'b00, cap_pend} - {2'b00, pop};
      rd_en        = (state == RUN) && (level < 3'd2);
      last_issue   = rd_en && (bank_cnt == 4'hF) && (addr_cnt == '1);
      fifo_cnt_nxt = fifo_cnt + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         bank_cnt <= '0;
         addr_cnt <= '0;
         sel_out  <= '0;
         cap_pend <= 1'b0;
      end else begin
         cap_pend <= rd_en;
         if (rd_en) begin
            sel_out  <= bank_seq;
            bank_cnt <= bank_cnt + 4'd1;
            if (bank_cnt == 4'hF) begin
               addr_cnt <= addr_cnt + ADDR_W'(1);
            end
         end
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               if (last_issue) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if ((fifo_cnt_nxt == 2'd0) && !cap_pend) begin
                  state <= FIN;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            FIN: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 2; i++) begin
            fifo_mem[i] <= '0;
         end
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= mux_q;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         fifo_cnt <= fifo_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_mux16_out_ctrl.sv
`timescale 1ns/1ps
`ifndef D_width
`define D_width 16
`endif

module tb_mux16_out_ctrl;

   localparam int AW = 1;
   localparam int NB = 16 * (1 << AW);
   localparam int DW = `D_width;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          out_ready = 1'b0;
   logic          busy, done, rd_en, out_valid;
   logic [AW-1:0] rd_addr;
   logic [3:0]    sel_out;
   logic [DW-1:0] mux_q, out_data;

   mux16_out_ctrl #(.ADDR_W(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .sel_out   (sel_out),
      .mux_q     (mux_q),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   // Bank contents and the external read path: data from the address
   // latched with rd_en and the bank named by sel_out. Without a read in
   // flight the mux shows the complement, so a stray capture is visible.
   logic [DW-1:0] mem [2][16];
   logic          pend_q = 1'b0;
   logic [AW-1:0] addr_q = '0;

   always @(posedge clk) begin
      pend_q <= rd_en;
      addr_q <= rd_addr;
   end

   always_comb begin
      mux_q = pend_q ? mem[addr_q][sel_out] : ~mem[addr_q][sel_out];
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned bank_of(input int unsigned b);
      int unsigned r;
      r = b;
`ifdef OUT_BITREV_EN
      r = 0;
      for (int i = 0; i < 4; i++) begin
         if (((b >> i) & 1) != 0) r = r | (1 << (3 - i));
      end
`endif
      return r;
   endfunction

   // Behavioural model state
   bit            active = 0;
   bit            fin_m = 0;
   int            issued = 0;
   int            delivered = 0;
   logic [DW-1:0] exp_q [$];
   int            cyc = 0;
   int            start_cyc = 0;
   int            first_valid_cyc = -1;
   int            last_beat_cyc = 0;
   int            done_cyc = 0;
   int            done_pulses = 0;
   int            beats = 0;
   bit            prev_stall = 0;
   logic [DW-1:0] prev_data = '0;
   int            low_run = 0;
   bit            pend_m = 0;
   int            pend_idx = 0;
   int unsigned   sel_log [$];

   always @(negedge clk) begin
      bit pop;
      cyc++;
      if (!rst_n) begin
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_rd_en", rd_en, 0);
         chk("rst_rd_addr", rd_addr, 0);
         chk("rst_sel_out", sel_out, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_data", out_data, 0);
         active = 0; fin_m = 0; issued = 0; delivered = 0;
         exp_q.delete();
         prev_stall = 0; pend_m = 0; low_run = 0;
      end else begin
         chk("busy", busy, active);
         chk("done", done, fin_m);
         if (done) begin
            done_pulses++;
            done_cyc = cyc;
         end
         if (!active) begin
            chk("idle_rd_en", rd_en, 0);
            chk("idle_out_valid", out_valid, 0);
         end
         if (pend_m) begin
            chk("sel_out", sel_out, bank_of(pend_idx % 16));
            sel_log.push_back(sel_out);
         end
         if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_data);
         end
         pop = out_valid && out_ready;
         if (rd_en) begin
            chk("rd_addr", rd_addr, issued / 16);
            chk("rd_credit", ((issued - delivered - int'(pop)) < 2), 1);
            chk("rd_count", (issued < NB), 1);
         end
         if (!out_ready) low_run++;
         else low_run = 0;
         if (low_run >= 3 && active) chk("rd_en_stall", rd_en, 0);
         if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (pop) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_beat: got %0h expected none at %0t", out_data, $time);
            end else begin
               chk("beat", out_data, exp_q.pop_front());
            end
            delivered++;
            beats++;
            last_beat_cyc = cyc;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         pend_m     = rd_en;
         pend_idx   = issued;
         if (rd_en) issued++;
         if (fin_m) begin
            fin_m = 0;
         end else if (active && pop && delivered == NB) begin
            active = 0;
            fin_m  = 1;
         end else if (!active && start) begin
            active = 1;
            issued = 0;
            delivered = 0;
            exp_q.delete();
            for (int a = 0; a < (1 << AW); a++)
               for (int b = 0; b < 16; b++)
                  exp_q.push_back(mem[a][bank_of(b)]);
            start_cyc = cyc;
            first_valid_cyc = -1;
         end
      end
   end

   task automatic do_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run_until_done(input int mode, input int budget);
      int n = 0;
      int stall = 0;
      bit stalled = 0;
      while (done_pulses == 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            2: out_ready = 1'($urandom_range(0, 1));
            default: begin
               if (!stalled && delivered >= 10) begin
                  stalled = 1;
                  stall = 5;
               end
               out_ready = (stall == 0);
               if (stall > 0) stall--;
            end
         endcase
      end
      if (done_pulses == 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: got no done expected done within %0d cycles", budget);
      end
      out_ready = 1'b1;
   endtask

   task automatic new_run();
      beats = 0;
      done_pulses = 0;
   endtask

   initial begin
      int unsigned sel_ref [16];
      int n;
      for (int a = 0; a < 2; a++)
         for (int b = 0; b < 16; b++)
            mem[a][b] = DW'($urandom);
`ifdef OUT_BITREV_EN
      sel_ref = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
      sel_ref = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Full readout with no back-pressure: latency, spacing, select order
      #1 out_ready = 1'b1;
      new_run();
      sel_log.delete();
      do_start();
      run_until_done(0, 300);
      chk("t1_beats", beats, 32);
      chk("t1_first_latency", first_valid_cyc - start_cyc, 3);
      chk("t1_consecutive", last_beat_cyc - first_valid_cyc, 31);
      chk("t1_done_after_last", done_cyc - last_beat_cyc, 1);
      chk("t1_done_pulses", done_pulses, 1);
      chk("t1_sel_count", sel_log.size(), 32);
      for (int i = 0; i < 32 && i < sel_log.size(); i++)
         chk("t1_sel_seq", sel_log[i], sel_ref[i % 16]);

      // Five-cycle stall mid-stream
      repeat (3) @(posedge clk);
      new_run();
      do_start();
      run_until_done(3, 300);
      chk("t2_beats", beats, 32);
      chk("t2_done_pulses", done_pulses, 1);

      // out_ready toggling every cycle
      repeat (3) @(posedge clk);
      new_run();
      do_start();
      run_until_done(1, 400);
      chk("t3_beats", beats, 32);

      // Random back-pressure, a few readouts
      for (int r = 0; r < 3; r++) begin
         repeat (2) @(posedge clk);
         new_run();
         do_start();
         run_until_done(2, 600);
         chk("t4_beats", beats, 32);
      end

      // start while busy and start during the done cycle are ignored
      repeat (3) @(posedge clk);
      new_run();
      do_start();
      repeat (5) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      while (!done && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("t5_done_pulses", done_pulses, 1);
      chk("t5_beats", beats, 32);
      chk("t5_idle_busy", busy, 0);

      // Reset at beat 10 aborts; a fresh start gives a full readout
      new_run();
      do_start();
      n = 0;
      while (delivered < 10 && n < 300) begin
         @(posedge clk);
         n++;
      end
      chk("t6_reached_beat10", (delivered >= 10), 1);
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      chk("t6_async_busy", busy, 0);
      chk("t6_async_rd_en", rd_en, 0);
      chk("t6_async_sel_out", sel_out, 0);
      chk("t6_async_rd_addr", rd_addr, 0);
      chk("t6_async_out_valid", out_valid, 0);
      chk("t6_async_out_data", out_data, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("t6_no_done", done_pulses, 0);
      chk("t6_idle_busy", busy, 0);
      new_run();
      do_start();
      run_until_done(0, 300);
      chk("t6_beats", beats, 32);
      chk("t6_done_pulses", done_pulses, 1);

      repeat (4) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global timeout");
   end

endmodule
